writeback_arbiter: RTL

Writeback stage feeding the register file write port (`wreg`/`wdata`/`wen`). Accepts completed results from three producers (ALU, load unit, mul/div unit) over valid/ready handshakes, grants one per cycle by round-robin, and formats load data (byte/half extract plus sign/zero extend). It drives one registered write per cycle, which clears the destination's scoreboard bit set at issue. It also pulses `retire` for instruction counting.

---
 rtl/wb_pkg.sv | 32 +++
 rtl/writeback_arbiter_if.sv | 43 ++++
 rtl/wb_load_format.sv | 40 ++++
 rtl/writeback_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load encodings,
// producer indices and the result bundle passed to the write port.
package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam int SRC_LOAD   = 0;
    localparam int SRC_MULDIV = 1;
    localparam int SRC_ALU    = 2;

    typedef logic [1:0] src_idx_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_res_t;

    // Round-robin successor over the three producers.
    function automatic src_idx_t rr_next(src_idx_t i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic f3_ok(logic [2:0] f);
        return f == F3_LB || f == F3_LH || f == F3_LW ||
               f == F3_LBU || f == F3_LHU;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Producer handshakes into the writeback stage and the
// register file write port it drives.
interface writeback_arbiter_if;

    logic        l_valid;
    logic        l_ready;
    logic [4:0]  l_rd;
    logic [31:0] l_word;
    logic [2:0]  l_funct3;
    logic [1:0]  l_addr;

    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_data;

    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        wen;
    logic        retire;

    modport master (
        output l_valid, l_rd, l_word, l_funct3, l_addr,
        output m_valid, m_rd, m_data,
        output a_valid, a_rd, a_data,
        input  l_ready, m_ready, a_ready,
        input  wreg, wdata, wen, retire
    );

    modport slave (
        input  l_valid, l_rd, l_word, l_funct3, l_addr,
        input  m_valid, m_rd, m_data,
        input  a_valid, a_rd, a_data,
        output l_ready, m_ready, a_ready,
        output wreg, wdata, wen, retire
    );

endinterface

// File: rtl/wb_load_format.sv
// Load data lane extract and sign/zero extension; purely combinational
// so a forwarding path can share it.
module wb_load_format (
    input  logic [31:0] l_word,
    input  logic [2:0]  l_funct3,
    input  logic [1:0]  l_addr,
    output logic [31:0] data
);
    import wb_pkg::*;

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = l_word[7:0];
        unique case (l_addr)
            2'd0: b = l_word[7:0];
            2'd1: b = l_word[15:8];
            2'd2: b = l_word[23:16];
            2'd3: b = l_word[31:24];
            default: b = l_word[7:0];
        endcase
    end

    // addr[0] is ignored for halfwords; misalignment traps earlier.
    assign h = l_addr[1] ? l_word[31:16] : l_word[15:0];

    always_comb begin
        data = '0;
        case (l_funct3)
            F3_LB:   data = {{24{b[7]}}, b};
            F3_LBU:  data = {24'b0, b};
            F3_LH:   data = {{16{h[15]}}, h};
            F3_LHU:  data = {16'b0, h};
            F3_LW:   data = l_word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: round-robin pick of one producer per cycle and a
// registered register-file write plus retire pulse.
module writeback_arbiter #(
    parameter int NSRC = 3
) (
    input logic            clk,
    input logic            reset_n,
    writeback_arbiter_if.slave bus
);
    import wb_pkg::*;

    logic [31:0]     ld_data;
    logic [NSRC-1:0] valid;
    logic [NSRC-1:0] gnt;
    wb_res_t         res [NSRC];
    wb_res_t         sel;
    src_idx_t        ptr;
    src_idx_t        gidx;

    wb_load_format u_fmt (
        .l_word   (bus.l_word),
        .l_funct3 (bus.l_funct3),
        .l_addr   (bus.l_addr),
        .data     (ld_data)
    );

    assign valid = {bus.a_valid, bus.m_valid, bus.l_valid};

    assign res[SRC_LOAD]   = '{rd: bus.l_rd, data: ld_data};
    assign res[SRC_MULDIV] = '{rd: bus.m_rd, data: bus.m_data};
    assign res[SRC_ALU]    = '{rd: bus.a_rd, data: bus.a_data};

    // Walk ptr, ptr+1, ptr+2 and take the first valid source.
    always_comb begin
        src_idx_t idx;
        gnt  = '0;
        gidx = ptr;
        idx  = ptr;
        for (int k = 0; k < NSRC; k++) begin
            if (reset_n && gnt == '0 && valid[idx]) begin
                gnt[idx] = 1'b1;
                gidx     = idx;
            end
            idx = rr_next(idx);
        end
    end

    assign bus.l_ready = gnt[SRC_LOAD];
    assign bus.m_ready = gnt[SRC_MULDIV];
    assign bus.a_ready = gnt[SRC_ALU];

    always_comb begin
        sel = '0;
        unique case (1'b1)
            gnt[SRC_LOAD]:   sel = res[SRC_LOAD];
            gnt[SRC_MULDIV]: sel = res[SRC_MULDIV];
            gnt[SRC_ALU]:    sel = res[SRC_ALU];
            default:         sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr        <= '0;
            bus.wen    <= 1'b0;
            bus.retire <= 1'b0;
            bus.wreg   <= '0;
            bus.wdata  <= '0;
        end else if (gnt != '0) begin
            ptr        <= rr_next(gidx);
            bus.wreg   <= sel.rd;
            bus.wdata  <= sel.data;
            bus.wen    <= (sel.rd != 5'd0);
            bus.retire <= 1'b1;
        end else begin
            bus.wen    <= 1'b0;
            bus.retire <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    // The issue scoreboard should make duplicate live rds impossible.
    always @(posedge clk) begin
        if (reset_n) begin
            if (bus.l_ready && !f3_ok(bus.l_funct3))
                $display("wb_arbiter: error: bad load funct3 %0d",
                         bus.l_funct3);
            for (int i = 0; i < NSRC; i++)
                for (int j = i + 1; j < NSRC; j++)
                    if (valid[i] && valid[j] &&
                        res[i].rd != 5'd0 && res[i].rd == res[j].rd)
                        $display("wb_arbiter: error: rd %0d from src %0d and %0d",
                                 res[i].rd, i, j);
        end
    end
`endif

endmodule
